// File: rtl/gray_conv_arbiter_if.sv
// Handshake bundle for gray_conv_arbiter: two request channels and one response channel.
// master = requesters/consumer side, slave = arbiter side.
interface gray_conv_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic             req0_mode;
    logic [WIDTH-1:0] req0_data;
    logic             req1_valid;
    logic             req1_ready;
    logic             req1_mode;
    logic [WIDTH-1:0] req1_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic             rsp_mode;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output req0_valid, req0_mode, req0_data,
        output req1_valid, req1_mode, req1_data,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_mode, rsp_data
    );

    modport slave (
        input  req0_valid, req0_mode, req0_data,
        input  req1_valid, req1_mode, req1_data,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_mode, rsp_data
    );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Two-requester round-robin arbiter in front of one shared binary<->Gray converter.
// Optional per-requester acceptance counters under GRAY_CONV_ARBITER_STATS_EN.
//
// state | meaning
// IDLE  | no result held, rsp_valid=0
// RESP  | result held on response port, rsp_valid=1
module gray_conv_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    gray_conv_arbiter_if.slave  bus
`ifdef GRAY_CONV_ARBITER_STATS_EN
    ,
    output logic [15:0]         acc0_cnt,
    output logic [15:0]         acc1_cnt
`endif
);

    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             can_accept;
    logic             ready0;
    logic             ready1;
    logic             accept;
    logic             grant_id;
    logic             sel_mode;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] conv_data;
    logic             rsp_id_q;
    logic             rsp_mode_q;
    logic [WIDTH-1:0] rsp_data_q;

    // One bit chain serves both directions: Gray->binary folds the running result,
    // binary->Gray folds the neighbouring input bit.
    function automatic logic [WIDTH-1:0] convert(input logic mode, input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        r = '0;
        r[WIDTH-1] = d[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            r[i] = mode ? (r[i+1] ^ d[i]) : (d[i+1] ^ d[i]);
        end
        return r;
    endfunction

    always_comb begin
        state_nxt  = state;
        ready0     = 1'b0;
        ready1     = 1'b0;
        can_accept = rst_n && ((state == IDLE) || bus.rsp_ready);
        if (can_accept) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (last_grant) ready0 = 1'b1;
                else            ready1 = 1'b1;
            end else if (bus.req0_valid) begin
                ready0 = 1'b1;
            end else if (bus.req1_valid) begin
                ready1 = 1'b1;
            end
        end
        accept   = ready0 | ready1;
        grant_id = ready1;
        if (accept) begin
            state_nxt = RESP;
        end else if ((state == RESP) && bus.rsp_ready) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        sel_mode  = grant_id ? bus.req1_mode : bus.req0_mode;
        sel_data  = grant_id ? bus.req1_data : bus.req0_data;
        conv_data = convert(sel_mode, sel_data);
    end

    // last_grant resets to 1 so requester 0 wins the first contested cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            rsp_id_q   <= 1'b0;
            rsp_mode_q <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                last_grant <= grant_id;
                rsp_id_q   <= grant_id;
                rsp_mode_q <= sel_mode;
                rsp_data_q <= conv_data;
            end
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_mode   = rsp_mode_q;
    assign bus.rsp_data   = rsp_data_q;

`ifdef GRAY_CONV_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc0_cnt <= '0;
            acc1_cnt <= '0;
        end else begin
            if (ready0 && (acc0_cnt != 16'hFFFF)) acc0_cnt <= acc0_cnt + 16'd1;
            if (ready1 && (acc1_cnt != 16'hFFFF)) acc1_cnt <= acc1_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/gray_conv_arbiter.md
GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the code word width in bits (legal range 2..16).
REQ-002 The block SHALL have the following ports, in this order:
- clk, input, 1: the single clock; all state updates on its rising edge.
- rst_n, input, 1: reset, synchronous and active-low.
- req0_valid, input, 1: requester 0 has a conversion pending.
- req0_ready, output, 1: requester 0's request is accepted this cycle.
- req0_mode, input, 1: conversion direction for requester 0; 0 = binary to Gray, 1 = Gray to binary.
- req0_data, input, WIDTH: operand from requester 0.
- req1_valid, input, 1: requester 1 has a conversion pending.
- req1_ready, output, 1: requester 1's request is accepted this cycle.
- req1_mode, input, 1: conversion direction for requester 1, encoded as for req0_mode.
- req1_data, input, WIDTH: operand from requester 1.
- rsp_valid, output, 1: a result is held on the response port.
- rsp_ready, input, 1: the consumer takes the result this cycle.
- rsp_id, output, 1: index of the requester that owns the result.
- rsp_mode, output, 1: conversion direction used for the result.
- rsp_data, output, WIDTH: converted result.

Function
REQ-003 A single shared conversion datapath SHALL serve both requesters, with the direction selected per transaction.
- Binary to Gray: G[MSB] = B[MSB]; G[i] = B[i+1] XOR B[i].
- Gray to binary: B[i] = XOR of G[MSB] down to G[i].
REQ-004 The FSM SHALL have exactly two states: IDLE (no result held) and RESP (result held, rsp_valid=1).
REQ-005 The block SHALL be able to accept a request when in IDLE, or when in RESP with rsp_ready=1 in the same cycle.
REQ-006 Request grant rules:
- A request is accepted when reqN_valid=1 and reqN_ready=1.
- reqN_ready SHALL be driven combinationally from the valids, the state, rsp_ready and the round-robin pointer.
- At most one reqN_ready SHALL be high in any cycle.
REQ-007 Arbitration SHALL be round-robin.
- With both valids high, the grant goes to the requester not granted most recently.
- With one valid high, that requester is granted.
- The last-grant pointer SHALL update only on acceptance.
REQ-008 Latency SHALL be exactly one cycle: a request accepted in cycle N gives rsp_valid=1 with the registered result in cycle N+1.
REQ-009 While rsp_valid=1 and rsp_ready=0, rsp_id, rsp_mode and rsp_data SHALL hold stable and both reqN_ready SHALL be 0.
REQ-010 Transitions:
- RESP with rsp_ready=1 and no acceptance goes to IDLE.
- RESP with rsp_ready=1 and a new acceptance stays in RESP with the new result (back-to-back, one result per cycle).
- IDLE with an acceptance goes to RESP.
REQ-011 In IDLE, rsp_valid SHALL be 0 and rsp_data SHALL retain its last value.
REQ-012 A requester SHALL keep reqN_valid, reqN_mode and reqN_data stable until accepted; the block SHALL NOT check this.

Reset
REQ-013 When rst_n=0 at a rising clk edge, the block SHALL reset as follows:
- State goes to IDLE.
- rsp_valid, rsp_id, rsp_mode and rsp_data go to 0.
- The round-robin pointer is set so requester 0 wins the first contested grant.
- Any held result is discarded.
REQ-014 During reset, req0_ready and req1_ready SHALL be 0.
REQ-015 Reset asserted while in RESP SHALL drop rsp_valid at the next edge with no handshake completed.

Configuration
REQ-016 Macro GRAY_CONV_ARBITER_STATS_EN SHALL control the statistics feature.
- When defined, the block SHALL add output ports acc0_cnt and acc1_cnt, each 16 bits.
- Each counter counts accepted requests for its requester and saturates at 16'hFFFF.
- Both counters reset to 0 under rst_n.
- When the macro is undefined, these ports and counters SHALL be absent and all other behaviour is identical.

Verification
REQ-017 req0 only, mode=0, data=4'b1011, rsp_ready=1 -> next cycle: rsp_valid=1, rsp_id=0, rsp_data=4'b1110.
REQ-018 req1 only, mode=1, data=4'b0111 -> rsp_id=1, rsp_data=4'b0101.
REQ-019 Both valids held high for 4 cycles after reset, rsp_ready=1 -> grants 0,1,0,1, one result per cycle, no bubbles.
REQ-020 Accept req0 (mode=0, data=4'b1000), then hold rsp_ready=0 for 3 cycles -> rsp_data=4'b1100 stable and both readys 0 throughout; it completes when rsp_ready=1.
REQ-021 rst_n=0 while in RESP -> next cycle rsp_valid=0 and pointer favours requester 0; with STATS_EN, both counters read 0.
REQ-022 With STATS_EN, preload acc0_cnt near saturation and accept 2 further req0 transactions -> acc0_cnt stays at 16'hFFFF.
